hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Drives the enable and flush controls of the PC, IF_ID and ID_EXE pipeline registers.
- Detects load-use hazards, holds the pipe during multi-cycle EXE operations, and flushes on taken branches.
- Generates the EXE-stage operand forwarding selects from the register addresses carried in ID_EXE.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   Drives enable/flush controls of the PC, IF_ID and ID_EXE registers,
//   resolves load-use hazards, holds the pipe for multi-cycle EXE ops,
//   flushes after taken branches and produces EXE forwarding selects.
// Ports:
//   clk_i_HZD_CTRL, rst_i_HZD_CTRL      clock, async active-low reset
//   id_rs1/rs2_addr_i, id_rs1/rs2_used_i  source registers of the ID instruction
//   exe_rs1/rs2_addr_i, exe_rd_addr_i     register addresses held in ID_EXE
//   exe_regWrite_i, exe_memRead_i         EXE instruction writes / is a load
//   mem_rd_addr_i, mem_regWrite_i         EX_MEM destination
//   wb_rd_addr_i, wb_regWrite_i           MEM_WB destination
//   branch_taken_i, mc_start_i, mc_done_i branch and multi-cycle op events
//   pc_en_o, if_id_en_o, if_id_flush_o, id_exe_en_o, id_exe_flush_o  pipe controls
//   fwdA_sel_o, fwdB_sel_o                00 regfile, 01 EX_MEM, 10 MEM_WB
//   state_o, mc_timeout_o, stall_cnt_o    FSM state, sticky timeout, stall counter
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i_HZD_CTRL,
    input  logic             rst_i_HZD_CTRL,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       exe_rs1_addr_i,
    input  logic [4:0]       exe_rs2_addr_i,
    input  logic [4:0]       exe_rd_addr_i,
    input  logic             exe_regWrite_i,
    input  logic             exe_memRead_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic             mem_regWrite_i,
    input  logic [4:0]       wb_rd_addr_i,
    input  logic             wb_regWrite_i,
    input  logic             branch_taken_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_exe_en_o,
    output logic             id_exe_flush_o,
    output logic [1:0]       fwdA_sel_o,
    output logic [1:0]       fwdB_sel_o,
    output logic [1:0]       state_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {RUN = 2'b00, MC_WAIT = 2'b01, FLUSH = 2'b10} state_e;
    localparam int TW = $clog2(MC_TIMEOUT + 1);
    // The branch cycle itself flushes in RUN, so FLUSH covers the remaining FLUSH_CYCLES-1.
    localparam logic [1:0]    FLUSH_LOAD = 2'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [TW-1:0] TMO_LAST   = TW'(MC_TIMEOUT - 1);
    state_e           state_q, state_d;
    logic [1:0]       flush_q, flush_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic [CNT_W-1:0] stall_q;
    logic             pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
    logic             load_use;
    logic [1:0]       fwd_a, fwd_b;
    // exe_regWrite_i is accepted for interface completeness; load-use only needs memRead.
    logic             unused_ok;
    assign unused_ok = exe_regWrite_i;
    assign load_use = exe_memRead_i & (|exe_rd_addr_i) &
                      ((id_rs1_used_i & (id_rs1_addr_i == exe_rd_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == exe_rd_addr_i)));
    // EX_MEM wins over MEM_WB; x0 never forwards.
    assign fwd_a = (mem_regWrite_i & (|mem_rd_addr_i) & (mem_rd_addr_i == exe_rs1_addr_i)) ? 2'b01 :
                   (wb_regWrite_i  & (|wb_rd_addr_i)  & (wb_rd_addr_i  == exe_rs1_addr_i)) ? 2'b10 : 2'b00;
    assign fwd_b = (mem_regWrite_i & (|mem_rd_addr_i) & (mem_rd_addr_i == exe_rs2_addr_i)) ? 2'b01 :
                   (wb_regWrite_i  & (|wb_rd_addr_i)  & (wb_rd_addr_i  == exe_rs2_addr_i)) ? 2'b10 : 2'b00;
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        state_d      = state_q;
        flush_d      = flush_q;
        tmo_d        = tmo_q;
        mc_timeout_d = mc_timeout_q;
        case (state_q)
            RUN: begin
                if (branch_taken_i) begin
                    if_id_flush  = 1'b1;
                    id_exe_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        flush_d = FLUSH_LOAD;
                    end
                end else if (mc_start_i) begin
                    tmo_d = '0;
                    // A start that completes in the same cycle behaves as a 1-cycle op.
                    if (!mc_done_i) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_exe_en = 1'b0;
                        state_d   = MC_WAIT;
                    end
                end else if (load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_exe_flush = 1'b1;
                end
            end
            MC_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (mc_done_i) begin
                    state_d = RUN;
                end else begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_exe_en = 1'b0;
                    if (tmo_q == TMO_LAST) begin
                        mc_timeout_d = 1'b1;
                        state_d      = RUN;
                    end
                end
            end
            FLUSH: begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
                if (branch_taken_i) begin
                    flush_d = FLUSH_LOAD;
                end else if (flush_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk_i_HZD_CTRL or negedge rst_i_HZD_CTRL) begin
        if (!rst_i_HZD_CTRL) begin
            state_q      <= RUN;
            flush_q      <= '0;
            tmo_q        <= '0;
            mc_timeout_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            tmo_q        <= tmo_d;
            mc_timeout_q <= mc_timeout_d;
            if (!pc_en && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + 1'b1;
        end
    end
    // Reset forces every combinational control to its inactive value.
    assign pc_en_o        = rst_i_HZD_CTRL & pc_en;
    assign if_id_en_o     = rst_i_HZD_CTRL & if_id_en;
    assign if_id_flush_o  = rst_i_HZD_CTRL & if_id_flush;
    assign id_exe_en_o    = rst_i_HZD_CTRL & id_exe_en;
    assign id_exe_flush_o = rst_i_HZD_CTRL & id_exe_flush;
    assign fwdA_sel_o     = rst_i_HZD_CTRL ? fwd_a : 2'b00;
    assign fwdB_sel_o     = rst_i_HZD_CTRL ? fwd_b : 2'b00;
    assign state_o        = state_q;
    assign mc_timeout_o   = mc_timeout_q;
    assign stall_cnt_o    = stall_q;
endmodule
